composite_frame_arbiter: RTL and testbench
==========================================

COMPOSITE_FRAME_ARBITER -- requirements
Module: composite_frame_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 160: pixels fetched per active line.
REQ-002 The block SHALL have parameter FIRST_ACTIVE_Y, default 17: first active line number.
REQ-003 The block SHALL have parameter LAST_ACTIVE_Y, default 256: last active line number.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 16: frame memory address width.
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 reset  input  1  reset; asynchronous, active-high.
REQ-007 y  input  10  current line number from the timing generator, 0..261.
REQ-008 hblank  input  1  horizontal blanking from the timing generator.
REQ-009 vblank  input  1  vertical blanking from the timing generator.
REQ-010 host_valid  input  1  host write request.
REQ-011 host_addr  input  ADDR_WIDTH  host write address.
REQ-012 host_data  input  8  host write data.
REQ-013 host_ready  output  1  host write accepted this cycle when host_valid is also high.
REQ-014 mem_en  output  1  frame memory access strobe.
REQ-015 mem_we  output  1  frame memory write enable; read when low.
REQ-016 mem_addr  output  ADDR_WIDTH  frame memory address.
REQ-017 mem_wdata  output  8  frame memory write data.
REQ-018 mem_rdata  input  8  frame memory read data, valid 1 cycle after a read strobe.
REQ-019 lb_we  output  1  line buffer write enable.
REQ-020 lb_waddr  output  9  line buffer write index, 0..LINE_WORDS-1.
REQ-021 lb_wdata  output  8  line buffer write data.
REQ-022 lb_bank  output  1  line buffer bank being written; the display reads ~lb_bank.
REQ-023 underrun  output  1  sticky flag: a fetch missed its deadline.

Function
REQ-024 The block SHALL detect fetch triggers as hblank rising edges (registered hblank 0, hblank 1) where y+1 lies in [FIRST_ACTIVE_Y, LAST_ACTIVE_Y].
REQ-025 The FSM SHALL have three states: IDLE, FETCH and HOST.
- IDLE->FETCH on a trigger or a pending trigger.
- IDLE->HOST on host_valid when no trigger is pending.
- HOST->IDLE after 1 cycle.
- FETCH->IDLE after the LINE_WORDS-th read strobe.
REQ-026 A trigger arriving in HOST SHALL be latched as pending and SHALL start FETCH on the next cycle.
REQ-027 When a trigger and host_valid occur in the same cycle, fetch SHALL win and host_ready SHALL be 0.
REQ-028 host_ready SHALL equal (state==IDLE and no trigger this cycle and none pending).
- Accepted write drives mem_en=1, mem_we=1, mem_addr=host_addr and mem_wdata=host_data in the same cycle.
REQ-029 In FETCH, the block SHALL issue one read per cycle (mem_en=1, mem_we=0, mem_addr=row_base+idx) for idx=0..LINE_WORDS-1.
REQ-030 One cycle after each read, the block SHALL assert lb_we=1 with lb_waddr=idx of that read and lb_wdata=mem_rdata.
REQ-031 row_base SHALL load 0 at the start of a fetch for line FIRST_ACTIVE_Y.
- Otherwise row_base SHALL increase by LINE_WORDS after each completed fetch.
- Addition SHALL be modulo 2^ADDR_WIDTH; no multiplier is used.
REQ-032 lb_bank SHALL toggle in the cycle after the final lb_we of a fetch.
REQ-033 If hblank falls while in FETCH, or a trigger arrives while in FETCH, underrun SHALL set.
- The fetch SHALL still run to completion; the extra trigger is dropped.
REQ-034 underrun SHALL clear on a vblank rising edge; a set condition in the same cycle wins.
REQ-035 When no access is in progress, mem_en, mem_we and lb_we SHALL be 0.

Reset
REQ-036 Reset SHALL act immediately, including mid-fetch, and force the following values:
- state=IDLE and the pending trigger cleared;
- row_base=0, idx=0 and lb_bank=0;
- underrun=0, host_ready=0;
- mem_en=0, mem_we=0 and lb_we=0;
- registered hblank=1, so no false edge occurs after release.
REQ-037 After reset, no fetch SHALL start until the next qualifying hblank rising edge.

Verification
REQ-038 hblank rises with y=16 -> 160 consecutive reads at addr 0..159; lb_we at idx 0..159 one cycle later; lb_bank 0->1.
REQ-039 hblank rises with y=17 after REQ-038 -> reads at addr 160..319; lb_bank 1->0; y=256 or y=10 -> no fetch.
REQ-040 host_valid held through a trigger -> host_ready=0 for the fetch's 160 cycles; the write completes on the first IDLE cycle after.
REQ-041 hblank falls at read 100 -> underrun=1 and the fetch completes; a vblank rising edge -> underrun=0.
REQ-042 Reset asserted at read 50 -> outputs go to reset values asynchronously; after release, the next trigger fetches with correct row_base.
REQ-043 Host write accepted in the same cycle as a trigger lands in HOST -> pending trigger; FETCH starts exactly 1 cycle later with no dropped reads.

Source files
------------

// File: rtl/composite_frame_arbiter.sv
`timescale 1ns/1ps
// composite_frame_arbiter
// Shares one frame-memory port between the host (byte writes) and the line
// fetcher. During horizontal blanking before each active line, the fetcher
// copies LINE_WORDS bytes into a double-buffered line buffer. A fetch always
// wins over the host. A fetch that misses its window raises a sticky underrun.
module composite_frame_arbiter #(
   parameter int LINE_WORDS     = 160,
   parameter int FIRST_ACTIVE_Y = 17,
   parameter int LAST_ACTIVE_Y  = 256,
   parameter int ADDR_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [9:0]            y,
   input  logic                  hblank,
   input  logic                  vblank,
   input  logic                  host_valid,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [7:0]            host_data,
   output logic                  host_ready,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   output logic                  lb_we,
   output logic [8:0]            lb_waddr,
   output logic [7:0]            lb_wdata,
   output logic                  lb_bank,
   output logic                  underrun
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOST  = 2'd2
   } state_t;

   localparam logic [10:0]           FIRST_Y  = 11'(FIRST_ACTIVE_Y);
   localparam logic [10:0]           LAST_Y   = 11'(LAST_ACTIVE_Y);
   localparam logic [8:0]            IDX_LAST = 9'(LINE_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(LINE_WORDS);

   state_t                state_q, state_d;
   logic                  pending_q, pending_d;
   logic                  hblank_q, vblank_q;
   logic [8:0]            idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
   logic                  underrun_q, underrun_d;
   logic                  lb_we_q, lb_last_q, lb_bank_q;
   logic [8:0]            lb_waddr_q;

   logic [10:0] y_next;
   logic        line_active, first_line;
   logic        trigger, hblank_fall, vblank_rise;
   logic        fetching, last_read;

   // The timing generator reports the line being displayed. The fetch is
   // for the line that follows it, so every qualification uses y+1.
   assign y_next      = {1'b0, y} + 11'd1;
   assign line_active = (y_next >= FIRST_Y) && (y_next <= LAST_Y);
   assign first_line  = (y_next == FIRST_Y);
   assign trigger     = hblank & ~hblank_q & line_active;
   assign hblank_fall = hblank_q & ~hblank;
   assign vblank_rise = vblank & ~vblank_q;
   assign fetching    = (state_q == ST_FETCH);
   assign last_read   = fetching && (idx_q == IDX_LAST);

   // Edge-detect history. It resets high so that an already-high blank
   // input cannot look like a rising edge right after reset is released.
   // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
      end else begin
         hblank_q <= hblank;
         vblank_q <= vblank;
      end
   end

   // FSM state register, including the trigger caught while serving the host.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   // FSM next state: a fetch pre-empts the host, and a host slot lasts one cycle.
   // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         ST_IDLE: begin
            if (trigger || pending_q) begin
               state_d = ST_FETCH;
            end else if (host_valid) begin
               state_d = ST_HOST;
            end
         end
         ST_HOST: begin
            if (trigger) begin
               pending_d = 1'b1;
            end
            state_d = (trigger || pending_q) ? ST_FETCH : ST_IDLE;
         end
         ST_FETCH: begin
            pending_d = 1'b0;
            if (last_read) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: a host write goes to memory in the same cycle it is accepted.
   // A fetch issues one read per cycle.
   always_comb begin
      host_ready = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = host_addr;
      mem_wdata  = host_data;
      case (state_q)
         ST_IDLE: begin
            // reset gates this term directly, so host_ready drops at once
            // while reset is held, even though the state register is already idle.
            host_ready = ~reset & ~trigger & ~pending_q;
            mem_en     = host_ready & host_valid;
            mem_we     = host_ready & host_valid;
         end
         ST_FETCH: begin
            mem_en   = 1'b1;
            mem_addr = row_base_q + ADDR_WIDTH'(idx_q);
         end
         default: ;
      endcase
   end

   // Fetch datapath next state: word index, row base and sticky underrun.
   always_comb begin
      idx_d      = idx_q;
      row_base_d = row_base_q;
      underrun_d = underrun_q;
      if (fetching) begin
         idx_d = last_read ? 9'd0 : idx_q + 9'd1;
      end
      // The first active line restarts the frame at address 0. Each
      // later line follows on from the previous one, without a multiply.
      if (trigger && !fetching && first_line) begin
         row_base_d = '0;
      end else if (last_read) begin
         row_base_d = row_base_q + ROW_STEP;
      end
      // If a deadline is missed in the same cycle as a vblank clear, the
      // set wins, so the error is not lost.
      if (fetching && (hblank_fall || trigger)) begin
         underrun_d = 1'b1;
      end else if (vblank_rise) begin
         underrun_d = 1'b0;
      end
   end

   // Fetch datapath registers. Line-buffer writes trail the reads by the
   // one-cycle memory latency, and the bank flips after the final write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q      <= '0;
         row_base_q <= '0;
         underrun_q <= 1'b0;
         lb_we_q    <= 1'b0;
         lb_waddr_q <= '0;
         lb_last_q  <= 1'b0;
         lb_bank_q  <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         row_base_q <= row_base_d;
         underrun_q <= underrun_d;
         lb_we_q    <= fetching;
         lb_waddr_q <= idx_q;
         lb_last_q  <= last_read;
         if (lb_we_q && lb_last_q) begin
            lb_bank_q <= ~lb_bank_q;
         end
      end
   end

   assign lb_we    = lb_we_q;
   assign lb_waddr = lb_waddr_q;
   assign lb_wdata = mem_rdata;
   assign lb_bank  = lb_bank_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_composite_frame_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for composite_frame_arbiter. The driver runs a
// transaction-level model of the arbiter and queues the memory accesses,
// line-buffer writes and status bits it expects in each cycle. A monitor
// on the falling edge pops those entries and compares them with the DUT.
module tb_composite_frame_arbiter;

   localparam int LW = 160;
   localparam int FY = 17;
   localparam int LY = 256;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [9:0]    y;
   logic          hblank, vblank;
   logic          host_valid;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_data;
   logic          host_ready;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata = 8'h00;
   logic          lb_we;
   logic [8:0]    lb_waddr;
   logic [7:0]    lb_wdata;
   logic          lb_bank;
   logic          underrun;

   always #5 clk = ~clk;

   composite_frame_arbiter #(
      .LINE_WORDS    (LW),
      .FIRST_ACTIVE_Y(FY),
      .LAST_ACTIVE_Y (LY),
      .ADDR_WIDTH    (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .y         (y),
      .hblank    (hblank),
      .vblank    (vblank),
      .host_valid(host_valid),
      .host_addr (host_addr),
      .host_data (host_data),
      .host_ready(host_ready),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .lb_we     (lb_we),
      .lb_waddr  (lb_waddr),
      .lb_wdata  (lb_wdata),
      .lb_bank   (lb_bank),
      .underrun  (underrun)
   );

   typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [7:0] data; } mem_exp_t;
   typedef struct { int cyc; logic [8:0] idx; logic [7:0] data; } lb_exp_t;
   typedef struct { int cyc; logic ready; logic under; logic bank; } st_exp_t;
   typedef struct { logic [AW-1:0] addr; logic [7:0] data; } host_req_t;

   mem_exp_t  mem_q[$];
   lb_exp_t   lb_q[$];
   st_exp_t   st_q[$];
   host_req_t hq[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit active   = 1'b0;
   int host_pct = 0;

   // stimulus levels held between steps
   logic       s_hb = 1'b1;
   logic       s_vb = 1'b0;
   logic [9:0] s_y  = 10'd0;

   // reference model state
   int            m_busy;
   logic          m_hold;
   logic [AW-1:0] m_row;
   logic          m_bank;
   int            m_flip;
   logic          m_under;
   logic          m_hbp, m_vbp;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_fn(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // frame memory: read data appears one cycle after the read strobe
   always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? mem_fn(mem_addr) : 8'h00;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_hold  = 1'b0;
      m_row   = '0;
      m_bank  = 1'b0;
      m_flip  = 0;
      m_under = 1'b0;
      m_hbp   = 1'b1;
      m_vbp   = 1'b1;
      mem_q.delete();
      lb_q.delete();
      st_q.delete();
   endtask

   task automatic drive();
      hblank     = s_hb;
      vblank     = s_vb;
      y          = s_y;
      host_valid = (hq.size() != 0);
      host_addr  = (hq.size() != 0) ? hq[0].addr : '0;
      host_data  = (hq.size() != 0) ? hq[0].data : 8'h00;
   endtask

   // One cycle of the arbitration rules. A fetch owns the next LW cycles.
   // A host write takes an idle cycle and is followed by one dead cycle.
   task automatic model_step();
      int            ln;
      int            idx;
      bit            in_rng, trig, fall, vrise, hr, set_u, last;
      logic [AW-1:0] a;
      ln     = int'(y) + 1;
      in_rng = (ln >= FY) && (ln <= LY);
      trig   = hblank && !m_hbp && in_rng;
      fall   = !hblank && m_hbp;
      vrise  = vblank && !m_vbp;
      hr = 0; set_u = 0; last = 0;
      if (m_busy > 0) begin
         idx = LW - m_busy;
         a   = m_row + AW'(idx);
         mem_q.push_back('{cyc, 1'b0, a, 8'h00});
         lb_q.push_back('{cyc + 1, 9'(idx), mem_fn(a)});
         if (trig || fall) set_u = 1;
         m_busy--;
         if (m_busy == 0) begin
            m_row = m_row + AW'(LW);
            last  = 1;
         end
      end else if (trig) begin
         m_busy = LW;
         if (ln == FY) m_row = '0;
         m_hold = 1'b0;
      end else if (m_hold) begin
         m_hold = 1'b0;
      end else begin
         hr = 1;
         if (host_valid) begin
            mem_q.push_back('{cyc, 1'b1, host_addr, host_data});
            void'(hq.pop_front());
            m_hold = 1'b1;
         end
      end
      st_q.push_back('{cyc, hr, m_under, m_bank});
      if (set_u) m_under = 1'b1;
      else if (vrise) m_under = 1'b0;
      if (m_flip > 0) begin
         m_flip--;
         if (m_flip == 0) m_bank = ~m_bank;
      end
      if (last) m_flip = 1;
      m_hbp = hblank;
      m_vbp = vblank;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (hq.size() < 4 && $urandom_range(0, 99) < host_pct)
         hq.push_back('{AW'($urandom), 8'($urandom)});
      drive();
      model_step();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic line_rise(input int yv, input int low, input int high);
      s_hb = 1'b0;
      run(low);
      s_hb = 1'b1;
      s_y  = 10'(yv);
      run(high);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_host_ready"}, 32'(host_ready), 32'd0);
      check({tag, "_mem_en"},     32'(mem_en),     32'd0);
      check({tag, "_mem_we"},     32'(mem_we),     32'd0);
      check({tag, "_lb_we"},      32'(lb_we),      32'd0);
      check({tag, "_underrun"},   32'(underrun),   32'd0);
      check({tag, "_lb_bank"},    32'(lb_bank),    32'd0);
   endtask

   task automatic release_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      active = 1'b1;
      drive();
      model_step();
   endtask

   // Asynchronous reset in the middle of a cycle, with a host write pending.
   task automatic reset_mid_cycle();
      #1;
      hq.push_back('{16'hBEEF, 8'h5A});
      reset = 1'b1;
      drive();
      #1;
      check_reset_outputs("rst_mid");
      model_reset();
      release_reset();
   endtask

   // monitor: compares the DUT against the queued expectations
   st_exp_t  mon_s;
   mem_exp_t mon_m;
   lb_exp_t  mon_l;
   always @(negedge clk) begin
      if (active && !reset) begin
         check("status_queued", 32'(st_q.size() != 0), 32'd1);
         if (st_q.size() != 0) begin
            mon_s = st_q.pop_front();
            check("status_cycle", 32'(cyc), 32'(mon_s.cyc));
            check("host_ready", 32'(host_ready), 32'(mon_s.ready));
            check("underrun", 32'(underrun), 32'(mon_s.under));
            check("lb_bank", 32'(lb_bank), 32'(mon_s.bank));
         end
         if (mem_en === 1'b1) begin
            check("mem_expected", 32'(mem_q.size() != 0), 32'd1);
            if (mem_q.size() != 0) begin
               mon_m = mem_q.pop_front();
               check("mem_cycle", 32'(cyc), 32'(mon_m.cyc));
               check("mem_we", 32'(mem_we), 32'(mon_m.we));
               check("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
               if (mon_m.we) check("mem_wdata", 32'(mem_wdata), 32'(mon_m.data));
            end
         end else begin
            check("mem_we_idle", 32'(mem_we), 32'd0);
            if (mem_q.size() != 0 && mem_q[0].cyc <= cyc) begin
               mon_m = mem_q.pop_front();
               check("mem_missing", 32'(mem_en), 32'd1);
            end
         end
         if (lb_we === 1'b1) begin
            check("lb_expected", 32'(lb_q.size() != 0), 32'd1);
            if (lb_q.size() != 0) begin
               mon_l = lb_q.pop_front();
               check("lb_cycle", 32'(cyc), 32'(mon_l.cyc));
               check("lb_waddr", 32'(lb_waddr), 32'(mon_l.idx));
               check("lb_wdata", 32'(lb_wdata), 32'(mon_l.data));
            end
         end else if (lb_q.size() != 0 && lb_q[0].cyc <= cyc) begin
            mon_l = lb_q.pop_front();
            check("lb_missing", 32'(lb_we), 32'd1);
         end
      end
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      model_reset();
      drive();
      #1;
      check_reset_outputs("rst_init");
      release_reset();

      // host writes on an idle bus
      host_pct = 40;
      run(20);
      host_pct = 0;
      run(10);

      // first active line, then the next line, then out-of-range lines, then the last line
      line_rise(16, 3, 170);
      line_rise(17, 3, 170);
      line_rise(256, 3, 20);
      line_rise(10, 3, 20);
      line_rise(255, 3, 170);

      // host request raised in the same cycle as a trigger and held throughout
      s_hb = 1'b0;
      run(3);
      hq.push_back('{16'h1234, 8'hA7});
      s_hb = 1'b1;
      s_y  = 10'd18;
      run(170);

      // trigger arrives during the HOST cycle after an accepted write
      s_hb = 1'b0;
      run(3);
      hq.push_back('{16'h4321, 8'h3E});
      step();
      s_hb = 1'b1;
      s_y  = 10'd19;
      run(170);

      // hblank falls at read 100, and a second trigger arrives mid-fetch
      s_hb = 1'b0;
      run(3);
      s_hb = 1'b1;
      s_y  = 10'd20;
      run(101);
      s_hb = 1'b0;
      run(10);
      s_hb = 1'b1;
      run(70);
      s_hb = 1'b0;
      run(5);
      s_vb = 1'b1;
      run(3);
      s_vb = 1'b0;
      run(3);

      // underrun set and vblank clear in the same cycle: the set wins
      s_hb = 1'b1;
      s_y  = 10'd21;
      run(50);
      s_hb = 1'b0;
      s_vb = 1'b1;
      step();
      s_vb = 1'b0;
      run(120);
      s_vb = 1'b1;
      run(2);
      s_vb = 1'b0;
      run(2);

      // asynchronous reset during read 50, then a fresh fetch
      s_hb = 1'b1;
      s_y  = 10'd22;
      run(52);
      reset_mid_cycle();
      run(5);
      line_rise(22, 3, 170);

      // randomized lines with background host traffic
      host_pct = 35;
      for (int i = 0; i < 20; i++) begin
         s_vb = 1'($urandom_range(0, 1));
         line_rise(($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(0, 261)),
                   int'($urandom_range(2, 30)), int'($urandom_range(10, 220)));
      end

      // drain
      host_pct = 0;
      s_hb = 1'b0;
      run(200);
      @(negedge clk);
      #1;
      active = 1'b0;
      check("mem_q_drained", 32'(mem_q.size()), 32'd0);
      check("lb_q_drained", 32'(lb_q.size()), 32'd0);
      check("st_q_drained", 32'(st_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
